// File: rtl/approx_err_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | approx_err_sweep_ctrl: exhaustive |a-b| error sweep of an approx circuit |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module approx_err_sweep_ctrl #(
  parameter int N_IN        = 4,
  parameter int OUT_W       = 3,
  parameter int SETTLE      = 0,
  parameter int EARLY_ABORT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OUT_W-1:0]  et,
  output logic [N_IN-1:0]   vec_out,
  input  logic [OUT_W-1:0]  approx_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [OUT_W-1:0]  max_err,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   worst_vec
);

  localparam int HALF = N_IN / 2;
  localparam logic [3:0] SETTLE_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t             r_state, w_next;
  logic [OUT_W-1:0]   r_et;
  logic [3:0]         r_settle;

  logic [HALF-1:0]    w_a, w_b, w_absd;
  logic [OUT_W-1:0]   w_exact, w_max_next;
  logic [OUT_W:0]     w_diff, w_err;
  logic               w_new_worst, w_abort, w_last;

  assign w_a         = vec_out[HALF-1:0];
  assign w_b         = vec_out[N_IN-1:HALF];
  assign w_absd      = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  assign w_exact     = OUT_W'(w_absd);
  // One extra bit keeps the signed difference unambiguous before taking magnitude
  assign w_diff      = {1'b0, approx_in} - {1'b0, w_exact};
  assign w_err       = w_diff[OUT_W] ? -w_diff : w_diff;
  assign w_new_worst = w_err > {1'b0, max_err};
  assign w_max_next  = w_new_worst ? w_err[OUT_W-1:0] : max_err;
  assign w_abort     = (EARLY_ABORT != 0) && (w_err > {1'b0, r_et});
  assign w_last      = &vec_out;

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (SETTLE > 0) ? DRIVE : SAMPLE;
      DRIVE:   if (r_settle == 4'd0) w_next = SAMPLE;
      SAMPLE: begin
        if (w_abort || w_last) w_next = DONE;
        else                   w_next = (SETTLE > 0) ? DRIVE : SAMPLE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_et      <= '0;
      r_settle  <= '0;
      vec_out   <= '0;
      max_err   <= '0;
      err_count <= '0;
      worst_vec <= '0;
      pass      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_et      <= et;
            r_settle  <= SETTLE_LD;
            vec_out   <= '0;
            max_err   <= '0;
            err_count <= '0;
            worst_vec <= '0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        end
        SAMPLE: begin
          if (w_err != '0) err_count <= err_count + (N_IN+1)'(1);
          // Strict compare: ties keep the earlier vector
          if (w_new_worst) begin
            max_err   <= w_err[OUT_W-1:0];
            worst_vec <= vec_out;
          end
          if (w_abort || w_last) begin
            pass <= (w_max_next <= r_et);
          end else begin
            vec_out  <= vec_out + N_IN'(1);
            r_settle <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
